// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a registered 4:1 data mux with a valid/ready output.
// Optional burst hold (re-grant the same requester up to BURST_LEN words) is enabled by ARB_BURST_EN.

module rr_mux_arbiter_chk #(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 4
) (
    input logic             clk,
    input logic             rstn,
    input logic [3:0]       gnt,
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] out,
    input logic             out_valid,
    input logic             out_ready
);

    burst_len_legal: assert property (@(posedge clk) disable iff (!rstn)
        (BURST_LEN >= 1) && (BURST_LEN <= 15));

    gnt_onehot0: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(gnt));

    gnt_tracks_valid: assert property (@(posedge clk) disable iff (!rstn)
        (gnt != 4'b0000) == out_valid);

    gnt_tracks_sel: assert property (@(posedge clk) disable iff (!rstn)
        out_valid |-> (gnt == (4'b0001 << sel)));

    // A stalled word must stay put until the consumer takes it.
    stall_holds_word: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(sel) && $stable(gnt)));

endmodule

module rr_mux_arbiter #(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_r;
    logic [1:0] ptr_r;

    logic       xfer_s;
    logic       arb_ev_s;
    logic [1:0] start_s;
    logic [1:0] cand_s;
    logic       win_found_s;
    logic [1:0] win_idx_s;
    logic       hold_s;
    logic       next_any_s;
    logic [1:0] next_idx_s;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic logic [WIDTH-1:0] pick_data(
        input logic [1:0]       idx,
        input logic [WIDTH-1:0] da,
        input logic [WIDTH-1:0] db,
        input logic [WIDTH-1:0] dc,
        input logic [WIDTH-1:0] dd
    );
        logic [WIDTH-1:0] v;
        case (idx)
            2'd0:    v = da;
            2'd1:    v = db;
            2'd2:    v = dc;
            2'd3:    v = dd;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Arbitration event and the search start; a transfer restarts the search just past the departing winner.
    always_comb begin
        xfer_s   = out_valid && out_ready;
        arb_ev_s = (state_r == ST_IDLE) || xfer_s;
        if (xfer_s) begin
            start_s = sel + 2'd1;
        end else begin
            start_s = ptr_r;
        end
    end

    // First requester in rotated priority order.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = start_s;
        cand_s      = start_s;
        for (int i = 0; i < 4; i++) begin
            cand_s = start_s + 2'(i);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

`ifdef ARB_BURST_EN
    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN - 1);

    logic [3:0] burst_cnt_r;

    // Burst hold: the current winner keeps the path while it still requests and has budget left.
    always_comb begin
        if (xfer_s && req[sel] && (burst_cnt_r < BURST_MAX)) begin
            hold_s = 1'b1;
        end else begin
            hold_s = 1'b0;
        end
    end

    // Burst counter: counts re-grants of the same requester, cleared by any other arbitration outcome.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            burst_cnt_r <= 4'd0;
        end else if (arb_ev_s) begin
            if (hold_s) begin
                burst_cnt_r <= burst_cnt_r + 4'd1;
            end else begin
                burst_cnt_r <= 4'd0;
            end
        end
    end
`else
    // Without burst support every transfer rotates.
    always_comb begin
        hold_s = 1'b0;
    end
`endif

    // Final winner for this arbitration event.
    always_comb begin
        if (hold_s) begin
            next_any_s = 1'b1;
            next_idx_s = sel;
        end else begin
            next_any_s = win_found_s;
            next_idx_s = win_idx_s;
        end
    end

    // Main FSM: loads grant, select and captured data on arbitration; holds everything while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (xfer_s && !hold_s) begin
                ptr_r <= sel + 2'd1;
            end
            if (arb_ev_s) begin
                if (next_any_s) begin
                    state_r   <= ST_GRANT;
                    gnt       <= idx_to_onehot(next_idx_s);
                    sel       <= next_idx_s;
                    out       <= pick_data(next_idx_s, a, b, c, d);
                    out_valid <= 1'b1;
                end else begin
                    state_r   <= ST_IDLE;
                    gnt       <= 4'b0000;
                    out_valid <= 1'b0;
                end
            end
        end
    end

    rr_mux_arbiter_chk #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN)
    ) u_chk (
        .clk       (clk),
        .rstn      (rstn),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a queue-based reference model predicts each granted word,
// a negedge monitor compares what the DUT presents; directed scenarios add fixed expectations.

module tb_rr_mux_arbiter;

    localparam int W  = 4;
    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic         out_ready = 1'b0;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] out;
    logic         out_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           sel;
        logic [W-1:0] data;
    } exp_t;

    exp_t q[$];
    bit   m_valid, cur_valid;
    int   m_sel, m_ptr, m_cnt;

    rr_mux_arbiter #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        cur_valid = 1'b0;
        m_sel     = 0;
        m_ptr     = 0;
        m_cnt     = 0;
        q.delete();
    endtask

    // Reference: what the arbiter should present after the coming rising edge.
    task automatic model_step();
        logic [W-1:0] dv[4];
        bit xfer, hold, found;
        int w;
        dv = '{a, b, c, d};
        cur_valid = m_valid;
        if (!rstn) begin
            model_reset();
            return;
        end
        xfer = m_valid && out_ready;
        if (m_valid && !xfer) return;
        hold = 1'b0;
`ifdef ARB_BURST_EN
        if (xfer && req[m_sel] && m_cnt < BL - 1) hold = 1'b1;
`endif
        if (xfer && !hold) m_ptr = (m_sel + 1) % 4;
        found = 1'b0;
        w = 0;
        if (hold) begin
            found = 1'b1;
            w = m_sel;
            m_cnt++;
        end else begin
            m_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && req[(m_ptr + i) % 4]) begin
                    found = 1'b1;
                    w = (m_ptr + i) % 4;
                end
            end
        end
        if (found) begin
            m_valid = 1'b1;
            m_sel = w;
            q.push_back('{w, dv[w]});
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] vc, input logic [W-1:0] vd, input logic rdy);
        @(negedge clk);
        rstn = 1'b1;
        req = r;
        a = va; b = vb; c = vc; d = vd;
        out_ready = rdy;
        model_step();
    endtask

    task automatic expect_now(input string tag, input bit v, input int s, input logic [W-1:0] o);
        #3;
        chk({tag, "_valid"}, out_valid, v);
        chk({tag, "_sel"}, sel, s);
        chk({tag, "_out"}, out, o);
        chk({tag, "_gnt"}, gnt, v ? (32'd1 << s) : 32'd0);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset();
        step(4'b0000, '0, '0, '0, '0, 1'b0);
        #4;
        rstn = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        model_reset();
        @(negedge clk);
        model_step();
    endtask

    // Monitor: compares the presented word with the scoreboard head; pops it when it transfers.
    always @(negedge clk) begin
        #2;
        chk("mon_valid", out_valid, cur_valid);
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_empty: DUT presents sel=%0d out=%0h but nothing expected", sel, out);
            end else begin
                chk("mon_sel", sel, q[0].sel);
                chk("mon_gnt", gnt, 32'd1 << q[0].sel);
                chk("mon_out", out, q[0].data);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        int burst_seq[9];
        #1;
        rstn = 1'b0;
        model_reset();

        // Reset while a word is stalled, then requester 0 wins first.
        do_reset();
        step(4'b0100, 4'h0, 4'h0, 4'h9, 4'h0, 1'b0);
        step(4'b0100, 4'h0, 4'h0, 4'h9, 4'h0, 1'b0);
        expect_now("pre_rst", 1'b1, 2, 4'h9);
        do_reset();
        step(4'b1001, 4'h3, 4'h0, 4'h0, 4'h8, 1'b0);
        step(4'b1001, 4'h3, 4'h0, 4'h0, 4'h8, 1'b1);
        expect_now("post_rst", 1'b1, 0, 4'h3);

        // Single requester, then release to idle.
        do_reset();
        step(4'b0100, 4'h0, 4'h0, 4'h9, 4'h0, 1'b1);
        step(4'b0000, 4'h0, 4'h0, 4'h9, 4'h0, 1'b1);
        expect_now("single", 1'b1, 2, 4'h9);
        step(4'b0000, 4'h0, 4'h0, 4'h9, 4'h0, 1'b1);
        expect_now("single_idle", 1'b0, 2, 4'h9);

        // Full rotation, back to back.
        do_reset();
        step(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
            expect_now("rot", 1'b1, i % 4, W'(i % 4 + 1));
        end

        // Backpressure on requester 1, then pointer fairness.
        do_reset();
        step(4'b0010, 4'h7, 4'h5, 4'h0, 4'hE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'h7, 4'hA, 4'h0, 4'hE, 1'b0);
            expect_now("stall", 1'b1, 1, 4'h5);
        end
        step(4'b1001, 4'h7, 4'hA, 4'h0, 4'hE, 1'b1);
        expect_now("stall_last", 1'b1, 1, 4'h5);
        step(4'b1001, 4'h7, 4'hA, 4'h0, 4'hE, 1'b1);
        expect_now("fair3", 1'b1, 3, 4'hE);
        step(4'b1001, 4'h7, 4'hA, 4'h0, 4'hE, 1'b1);
        expect_now("fair0", 1'b1, 0, 4'h7);

        // Two steady requesters: bursts when enabled, strict alternation otherwise.
`ifdef ARB_BURST_EN
        burst_seq = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
`else
        burst_seq = '{1, 2, 1, 2, 1, 2, 1, 2, 1};
`endif
        do_reset();
        step(4'b0110, 4'h0, 4'h3, 4'h6, 4'h0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(4'b0110, 4'h0, 4'h3, 4'h6, 4'h0, 1'b1);
            expect_now("burst", 1'b1, burst_seq[i], (burst_seq[i] == 1) ? 4'h3 : 4'h6);
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), W'($urandom),
                     W'($urandom), ($urandom_range(0, 3) != 0));
            end
        end
        step(4'b0000, '0, '0, '0, '0, 1'b1);
        step(4'b0000, '0, '0, '0, '0, 1'b1);
        step(4'b0000, '0, '0, '0, '0, 1'b1);
        #3;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
